// File: rtl/link_stats_monitor.sv
// link_stats_monitor
// Multi-lane RX link statistics monitor. For every lane it accumulates ones,
// transitions, counted samples, the longest same-bit run and CDR lock-loss
// events over windows of 2^WINDOW_LOG2 UI strobes. At each window close it
// publishes one snapshot of all lanes through a valid/ready handshake.
module link_stats_monitor #(
  parameter int NUM_LANES   = 4,
  parameter int WINDOW_LOG2 = 16,
  parameter int CNT_W       = WINDOW_LOG2 + 1,
  parameter int RUN_W       = 8,
  parameter int LOCK_W      = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        sample_en,
  input  logic [NUM_LANES-1:0]        serial_in,
  input  logic [NUM_LANES-1:0]        cdr_lock,
  input  logic                        gate_on_lock,
  input  logic                        clear,
  output logic                        snap_valid,
  input  logic                        snap_ready,
  output logic [NUM_LANES*CNT_W-1:0]  snap_ones,
  output logic [NUM_LANES*CNT_W-1:0]  snap_trans,
  output logic [NUM_LANES*CNT_W-1:0]  snap_samples,
  output logic [NUM_LANES*RUN_W-1:0]  snap_maxrun,
  output logic [NUM_LANES*LOCK_W-1:0] snap_lockloss,
  output logic [15:0]                 snap_seq,
  output logic                        snap_overrun
);

  localparam logic [WINDOW_LOG2-1:0] WIN_LAST = '1;
  localparam logic [WINDOW_LOG2-1:0] WIN_ONE  = WINDOW_LOG2'(1);
  localparam logic [RUN_W-1:0]       RUN_MAX  = '1;
  localparam logic [RUN_W-1:0]       RUN_ONE  = RUN_W'(1);
  localparam logic [LOCK_W-1:0]      LOCK_MAX = '1;
  localparam logic [LOCK_W-1:0]      LOCK_ONE = LOCK_W'(1);

  // Per-lane window accumulators and history
  logic [CNT_W-1:0]       r_ones     [NUM_LANES];
  logic [CNT_W-1:0]       r_trans    [NUM_LANES];
  logic [CNT_W-1:0]       r_samples  [NUM_LANES];
  logic [RUN_W-1:0]       r_maxrun   [NUM_LANES];
  logic [LOCK_W-1:0]      r_lockloss [NUM_LANES];
  logic [RUN_W-1:0]       r_run_len  [NUM_LANES];
  logic [NUM_LANES-1:0]   r_prev_bit;
  logic [NUM_LANES-1:0]   r_prev_valid;
  logic [NUM_LANES-1:0]   r_prev_lock;
  logic [WINDOW_LOG2-1:0] r_win_cnt;

  // Published snapshot
  logic [NUM_LANES*CNT_W-1:0]  r_snap_ones;
  logic [NUM_LANES*CNT_W-1:0]  r_snap_trans;
  logic [NUM_LANES*CNT_W-1:0]  r_snap_samples;
  logic [NUM_LANES*RUN_W-1:0]  r_snap_maxrun;
  logic [NUM_LANES*LOCK_W-1:0] r_snap_lockloss;
  logic [15:0]                 r_snap_seq;
  logic                        r_snap_valid;
  logic                        r_snap_overrun;

  // Next-state values including the current cycle's contribution
  logic                   w_close;
  logic [NUM_LANES-1:0]   w_counted;
  logic [NUM_LANES-1:0]   w_changed;
  logic [NUM_LANES-1:0]   w_trans_inc;
  logic [RUN_W-1:0]       w_run_nxt     [NUM_LANES];
  logic [CNT_W-1:0]       w_ones_nxt    [NUM_LANES];
  logic [CNT_W-1:0]       w_trans_nxt   [NUM_LANES];
  logic [CNT_W-1:0]       w_samples_nxt [NUM_LANES];
  logic [RUN_W-1:0]       w_maxrun_nxt  [NUM_LANES];
  logic [LOCK_W-1:0]      w_lockloss_nxt[NUM_LANES];

  // Compute per-lane updated statistics for this cycle (used both for
  // accumulation and for the snapshot taken on the closing sample)
  always_comb begin
    w_close = sample_en & (r_win_cnt == WIN_LAST);
    for (int l = 0; l < NUM_LANES; l++) begin
      w_counted[l]   = sample_en & (~gate_on_lock | cdr_lock[l]);
      w_changed[l]   = ~r_prev_valid[l] | (serial_in[l] ^ r_prev_bit[l]);
      w_trans_inc[l] = w_counted[l] & r_prev_valid[l] & (serial_in[l] ^ r_prev_bit[l]);

      if (!sample_en) begin
        w_run_nxt[l] = r_run_len[l];
      end else if (w_changed[l]) begin
        w_run_nxt[l] = RUN_ONE;
      end else if (r_run_len[l] == RUN_MAX) begin
        w_run_nxt[l] = RUN_MAX;
      end else begin
        w_run_nxt[l] = r_run_len[l] + RUN_ONE;
      end

      w_ones_nxt[l]    = r_ones[l]    + CNT_W'(w_counted[l] & serial_in[l]);
      w_trans_nxt[l]   = r_trans[l]   + CNT_W'(w_trans_inc[l]);
      w_samples_nxt[l] = r_samples[l] + CNT_W'(w_counted[l]);

      if (w_counted[l] && (w_run_nxt[l] > r_maxrun[l])) begin
        w_maxrun_nxt[l] = w_run_nxt[l];
      end else begin
        w_maxrun_nxt[l] = r_maxrun[l];
      end

      // lock loss is a falling edge of cdr_lock, counted every clock
      if (r_prev_lock[l] && !cdr_lock[l] && (r_lockloss[l] != LOCK_MAX)) begin
        w_lockloss_nxt[l] = r_lockloss[l] + LOCK_ONE;
      end else begin
        w_lockloss_nxt[l] = r_lockloss[l];
      end
    end
  end

  // Window accumulation, window close snapshot and handshake state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int l = 0; l < NUM_LANES; l++) begin
        r_ones[l]     <= '0;
        r_trans[l]    <= '0;
        r_samples[l]  <= '0;
        r_maxrun[l]   <= '0;
        r_lockloss[l] <= '0;
        r_run_len[l]  <= '0;
      end
      r_prev_bit      <= '0;
      r_prev_valid    <= '0;
      r_prev_lock     <= '0;
      r_win_cnt       <= '0;
      r_snap_ones     <= '0;
      r_snap_trans    <= '0;
      r_snap_samples  <= '0;
      r_snap_maxrun   <= '0;
      r_snap_lockloss <= '0;
      r_snap_seq      <= '0;
      r_snap_valid    <= 1'b0;
      r_snap_overrun  <= 1'b0;
    end else if (clear) begin
      // clear restarts the window; snapshot data and sequence are retained
      for (int l = 0; l < NUM_LANES; l++) begin
        r_ones[l]     <= '0;
        r_trans[l]    <= '0;
        r_samples[l]  <= '0;
        r_maxrun[l]   <= '0;
        r_lockloss[l] <= '0;
        r_run_len[l]  <= '0;
      end
      r_prev_valid   <= '0;
      r_prev_lock    <= cdr_lock;
      r_win_cnt      <= '0;
      r_snap_valid   <= 1'b0;
      r_snap_overrun <= 1'b0;
    end else begin
      r_prev_lock <= cdr_lock;
      if (sample_en) begin
        r_prev_bit   <= serial_in;
        r_prev_valid <= '1;
        r_win_cnt    <= r_win_cnt + WIN_ONE;
        for (int l = 0; l < NUM_LANES; l++) begin
          r_run_len[l] <= w_run_nxt[l];
        end
      end
      if (w_close) begin
        for (int l = 0; l < NUM_LANES; l++) begin
          r_snap_ones[l*CNT_W +: CNT_W]      <= w_ones_nxt[l];
          r_snap_trans[l*CNT_W +: CNT_W]     <= w_trans_nxt[l];
          r_snap_samples[l*CNT_W +: CNT_W]   <= w_samples_nxt[l];
          r_snap_maxrun[l*RUN_W +: RUN_W]    <= w_maxrun_nxt[l];
          r_snap_lockloss[l*LOCK_W +: LOCK_W] <= w_lockloss_nxt[l];
          r_ones[l]     <= '0;
          r_trans[l]    <= '0;
          r_samples[l]  <= '0;
          r_maxrun[l]   <= '0;
          r_lockloss[l] <= '0;
        end
        r_snap_seq     <= r_snap_seq + 16'd1;
        r_snap_valid   <= 1'b1;
        // overwriting a snapshot the consumer has not taken is sticky
        r_snap_overrun <= r_snap_overrun | (r_snap_valid & ~snap_ready);
      end else begin
        for (int l = 0; l < NUM_LANES; l++) begin
          r_ones[l]     <= w_ones_nxt[l];
          r_trans[l]    <= w_trans_nxt[l];
          r_samples[l]  <= w_samples_nxt[l];
          r_maxrun[l]   <= w_maxrun_nxt[l];
          r_lockloss[l] <= w_lockloss_nxt[l];
        end
        if (r_snap_valid && snap_ready) begin
          r_snap_valid <= 1'b0;
        end else begin
          r_snap_valid <= r_snap_valid;
        end
      end
    end
  end

  assign snap_valid    = r_snap_valid;
  assign snap_ones     = r_snap_ones;
  assign snap_trans    = r_snap_trans;
  assign snap_samples  = r_snap_samples;
  assign snap_maxrun   = r_snap_maxrun;
  assign snap_lockloss = r_snap_lockloss;
  assign snap_seq      = r_snap_seq;
  assign snap_overrun  = r_snap_overrun;

endmodule
